// File: rtl/scr_stack_ctrl.sv
// Stack controller over an external scratch RAM (sync write, async read).
// The stack grows downward from SP; CLEAR zero-fills the whole RAM over 2**ADDR_W cycles.
module scr_stack_ctrl #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic              CLEAR,
    input  logic [DATA_W-1:0] PUSH_DATA,
    output logic [DATA_W-1:0] POP_DATA,
    output logic              POP_VALID,
    output logic [ADDR_W-1:0] SP,
    output logic              FULL,
    output logic              EMPTY,
    output logic              BUSY,
    output logic              ERR,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic [DATA_W-1:0] SCR_DATA_OUT,
    output logic              SCR_WE,
    input  logic [DATA_W-1:0] SCR_DATA_IN
);

    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_CLR   = 1'b1;
    localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_A   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] sp_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic [DATA_W-1:0] pop_data_r;
    logic              pop_valid_r;
    logic              err_r;

    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              repl_s;
    logic              err_set_s;
    logic              start_clr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              we_s;

    assign full_s  = (count_r == CNT_MAX);
    assign empty_s = (count_r == CNT_ZERO);

    // Request arbitration and scratch RAM port drive for the current cycle.
    always_comb begin
        push_ok_s   = 1'b0;
        pop_ok_s    = 1'b0;
        repl_s      = 1'b0;
        err_set_s   = 1'b0;
        start_clr_s = 1'b0;
        addr_s      = sp_r;
        wdata_s     = {DATA_W{1'b0}};
        we_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (CLEAR) begin
                    start_clr_s = 1'b1;
                end else if (PUSH && POP) begin
                    if (empty_s) begin
                        push_ok_s = 1'b1;
                    end else begin
                        repl_s = 1'b1;
                    end
                end else if (PUSH) begin
                    if (full_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        push_ok_s = 1'b1;
                    end
                end else if (POP) begin
                    if (empty_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        pop_ok_s = 1'b1;
                    end
                end else begin
                    start_clr_s = 1'b0;
                end

                // Replace-top writes at SP while the async read still returns the old top.
                if (push_ok_s) begin
                    addr_s  = sp_r - ONE_A;
                    wdata_s = PUSH_DATA;
                    we_s    = 1'b1;
                end else if (repl_s) begin
                    addr_s  = sp_r;
                    wdata_s = PUSH_DATA;
                    we_s    = 1'b1;
                end else begin
                    addr_s  = sp_r;
                end
            end
            ST_CLR: begin
                addr_s  = clr_addr_r;
                wdata_s = {DATA_W{1'b0}};
                we_s    = 1'b1;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Stack pointer, occupancy, clear sequencing and registered pop results.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            sp_r        <= {ADDR_W{1'b0}};
            count_r     <= CNT_ZERO;
            clr_addr_r  <= {ADDR_W{1'b0}};
            pop_data_r  <= {DATA_W{1'b0}};
            pop_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            pop_valid_r <= pop_ok_s | repl_s;
            if (pop_ok_s || repl_s) begin
                pop_data_r <= SCR_DATA_IN;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_clr_s) begin
                        state_r    <= ST_CLR;
                        clr_addr_r <= {ADDR_W{1'b0}};
                    end else if (push_ok_s) begin
                        sp_r    <= sp_r - ONE_A;
                        count_r <= count_r + ONE_C;
                    end else if (pop_ok_s) begin
                        sp_r    <= sp_r + ONE_A;
                        count_r <= count_r - ONE_C;
                    end
                end
                ST_CLR: begin
                    clr_addr_r <= clr_addr_r + ONE_A;
                    if (clr_addr_r == LAST_A) begin
                        state_r <= ST_IDLE;
                        sp_r    <= {ADDR_W{1'b0}};
                        count_r <= CNT_ZERO;
                        err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign POP_DATA     = pop_data_r;
    assign POP_VALID    = pop_valid_r;
    assign SP           = sp_r;
    assign FULL         = full_s;
    assign EMPTY        = empty_s;
    assign BUSY         = (state_r == ST_CLR);
    assign ERR          = err_r;
    assign SCR_ADDR     = addr_s;
    assign SCR_DATA_OUT = wdata_s;
    assign SCR_WE       = we_s & ~RST;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Directed bench for scr_stack_ctrl with a scratch RAM model and a pop-data scoreboard.
module tb_scr_stack_ctrl;

    logic       clk = 1'b0;
    logic       RST;
    logic       PUSH, POP, CLEAR;
    logic [9:0] PUSH_DATA;
    logic [9:0] POP_DATA;
    logic       POP_VALID;
    logic [7:0] SP;
    logic       FULL, EMPTY, BUSY, ERR;
    logic [7:0] SCR_ADDR;
    logic [9:0] SCR_DATA_OUT;
    logic       SCR_WE;
    logic [9:0] SCR_DATA_IN;

    logic [9:0] mem [256];
    logic [9:0] exp_q [$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    scr_stack_ctrl #(.DATA_W(10), .ADDR_W(8)) dut (
        .clk(clk), .RST(RST), .PUSH(PUSH), .POP(POP), .CLEAR(CLEAR),
        .PUSH_DATA(PUSH_DATA), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID),
        .SP(SP), .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY), .ERR(ERR),
        .SCR_ADDR(SCR_ADDR), .SCR_DATA_OUT(SCR_DATA_OUT), .SCR_WE(SCR_WE),
        .SCR_DATA_IN(SCR_DATA_IN)
    );

    always #5 clk = ~clk;

    // Scratch RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (SCR_WE) mem[SCR_ADDR] <= SCR_DATA_OUT;
    end
    assign SCR_DATA_IN = mem[SCR_ADDR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Scoreboard monitor: every POP_VALID strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!RST && POP_VALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_valid", 32'd1, 32'd0);
            end else begin
                chk("pop_data", {22'd0, POP_DATA}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        PUSH = 1'b1; PUSH_DATA = d;
        tick();
        PUSH = 1'b0;
    endtask

    task automatic pop(input logic [9:0] e);
        POP = 1'b1;
        exp_q.push_back(e);
        tick();
        POP = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int nz;
        for (int i = 0; i < 256; i++) mem[i] = 10'h0AB;
        RST = 1'b1; PUSH = 1'b1; POP = 1'b0; CLEAR = 1'b0; PUSH_DATA = 10'h111;
        #3;
        chk("rst_sp", {24'd0, SP}, 32'd0);
        chk("rst_empty", {31'd0, EMPTY}, 32'd1);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_we_forced", {31'd0, SCR_WE}, 32'd0);
        chk("rst_pop_data", {22'd0, POP_DATA}, 32'd0);
        PUSH = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("idle_we", {31'd0, SCR_WE}, 32'd0);

        // Two pushes land at 255 then 254.
        PUSH = 1'b1; PUSH_DATA = 10'h155; #1;
        chk("push1_addr", {24'd0, SCR_ADDR}, 32'd255);
        chk("push1_we", {31'd0, SCR_WE}, 32'd1);
        tick();
        PUSH_DATA = 10'h2AA; #1;
        chk("push2_addr", {24'd0, SCR_ADDR}, 32'd254);
        tick();
        PUSH = 1'b0;
        chk("push_sp", {24'd0, SP}, 32'd254);
        chk("push_empty", {31'd0, EMPTY}, 32'd0);
        chk("mem255", {22'd0, mem[255]}, 32'h155);
        chk("mem254", {22'd0, mem[254]}, 32'h2AA);

        // Two pops return LIFO order.
        pop(10'h2AA);
        pop(10'h155);
        chk("pop_sp", {24'd0, SP}, 32'd0);
        chk("pop_empty", {31'd0, EMPTY}, 32'd1);
        tick();

        // Underflow.
        POP = 1'b1; #1;
        chk("uflow_we", {31'd0, SCR_WE}, 32'd0);
        tick();
        POP = 1'b0;
        chk("uflow_err", {31'd0, ERR}, 32'd1);
        chk("uflow_sp", {24'd0, SP}, 32'd0);
        tick();
        chk("uflow_no_valid", {31'd0, POP_VALID}, 32'd0);

        // Fill to 256 words, then overflow.
        for (int i = 0; i < 256; i++) push(10'(i));
        chk("full_flag", {31'd0, FULL}, 32'd1);
        chk("full_sp", {24'd0, SP}, 32'd0);
        chk("err_sticky", {31'd0, ERR}, 32'd1);
        PUSH = 1'b1; PUSH_DATA = 10'h3CC; #1;
        chk("oflow_we", {31'd0, SCR_WE}, 32'd0);
        tick();
        PUSH = 1'b0;
        chk("oflow_sp", {24'd0, SP}, 32'd0);
        chk("oflow_err", {31'd0, ERR}, 32'd1);
        chk("oflow_full", {31'd0, FULL}, 32'd1);

        // Drain; the final pop wraps SP from 255 to 0.
        for (int i = 255; i >= 0; i--) pop(10'(i));
        chk("drain_empty", {31'd0, EMPTY}, 32'd1);
        chk("drain_sp", {24'd0, SP}, 32'd0);

        // PUSH+POP while empty acts as a push.
        PUSH = 1'b1; POP = 1'b1; PUSH_DATA = 10'h123; #1;
        chk("pp_empty_addr", {24'd0, SCR_ADDR}, 32'd255);
        tick();
        PUSH = 1'b0; POP = 1'b0;
        chk("pp_empty_sp", {24'd0, SP}, 32'd255);
        pop(10'h123);

        // Replace top.
        push(10'h001);
        PUSH = 1'b1; POP = 1'b1; PUSH_DATA = 10'h3FF; #1;
        chk("repl_addr", {24'd0, SCR_ADDR}, 32'd255);
        chk("repl_we", {31'd0, SCR_WE}, 32'd1);
        exp_q.push_back(10'h001);
        tick();
        PUSH = 1'b0; POP = 1'b0;
        tick();
        chk("repl_mem", {22'd0, mem[255]}, 32'h3FF);
        chk("repl_sp", {24'd0, SP}, 32'd255);
        chk("repl_empty", {31'd0, EMPTY}, 32'd0);
        chk("err_before_clear", {31'd0, ERR}, 32'd1);

        // Full clear with requests injected while busy.
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        n = 0;
        while (BUSY && n < 300) begin
            if (n == 10) begin
                PUSH = 1'b1; POP = 1'b1; PUSH_DATA = 10'h2F0;
            end else begin
                PUSH = 1'b0; POP = 1'b0;
            end
            if (n == 20) chk("busy_err_held", {31'd0, ERR}, 32'd1);
            tick();
            n++;
        end
        PUSH = 1'b0; POP = 1'b0;
        chk("clear_cycles", n, 32'd256);
        chk("clear_sp", {24'd0, SP}, 32'd0);
        chk("clear_empty", {31'd0, EMPTY}, 32'd1);
        chk("clear_err", {31'd0, ERR}, 32'd0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 10'h000) nz++;
        chk("clear_ram_zero", nz, 32'd0);

        // Reset in the middle of a clear.
        push(10'h2AA);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("midclr_busy", {31'd0, BUSY}, 32'd1);
        RST = 1'b1; #2;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_we", {31'd0, SCR_WE}, 32'd0);
        chk("abort_sp", {24'd0, SP}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        chk("abort_idle", {31'd0, BUSY}, 32'd0);
        chk("abort_mem99", {22'd0, mem[99]}, 32'h000);
        chk("abort_mem255_kept", {22'd0, mem[255]}, 32'h2AA);

        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/scr_stack_ctrl.md
SCR_STACK_CTRL -- requirements
Module: scr_stack_ctrl

Interface
REQ-001 Parameter DATA_W, default 10: width of a stack word and of the scratch RAM data port.
REQ-002 Parameter ADDR_W, default 8: scratch RAM address width; stack depth is 2**ADDR_W (256).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named `clk` and `RST`.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- RST  in  1  asynchronous reset, active-high.
- PUSH  in  1  push request, sampled at a rising edge.
- POP  in  1  pop request, sampled at a rising edge.
- CLEAR  in  1  request to zero-fill the RAM and empty the stack.
- PUSH_DATA  in  DATA_W  word to push.
- POP_DATA  out  DATA_W  registered popped word.
- POP_VALID  out  1  one-cycle strobe: POP_DATA has been updated.
- SP  out  ADDR_W  current stack pointer.
- FULL  out  1  stack holds 256 words.
- EMPTY  out  1  stack holds 0 words.
- BUSY  out  1  clear sequence in progress.
- ERR  out  1  sticky overflow/underflow flag.
- SCR_ADDR  out  ADDR_W  address to scratch RAM.
- SCR_DATA_OUT  out  DATA_W  write data to the RAM DATA_IN port.
- SCR_WE  out  1  RAM write enable.
- SCR_DATA_IN  in  DATA_W  RAM asynchronous read data.

Function
REQ-005 The RAM SHALL be treated as a synchronous-write, asynchronous-read memory; all SCR_* outputs SHALL be combinational from the current state and request inputs.
REQ-006 The block SHALL keep a 9-bit COUNT register (0..256); FULL = (COUNT==256) and EMPTY = (COUNT==0), both combinational.
REQ-007 The FSM SHALL have two states, IDLE and CLR.
REQ-008 In IDLE, request priority SHALL be CLEAR, then PUSH together with POP, then PUSH alone, then POP alone.
REQ-009 PUSH alone while not FULL: SCR_ADDR = SP-1 (mod 256), SCR_DATA_OUT = PUSH_DATA, SCR_WE = 1 in the same cycle; at the edge SP <= SP-1 and COUNT += 1.
REQ-010 POP alone while not EMPTY: SCR_ADDR = SP and SCR_WE = 0; at the edge POP_DATA <= SCR_DATA_IN, POP_VALID <= 1, SP <= SP+1 (mod 256), COUNT -= 1.
REQ-011 PUSH and POP together while not EMPTY (replace top): SCR_ADDR = SP and SCR_WE = 1 with PUSH_DATA; POP_DATA SHALL capture the old top, POP_VALID <= 1, and SP and COUNT SHALL be unchanged.
REQ-012 PUSH and POP together while EMPTY SHALL behave as PUSH alone, with no error.
REQ-013 PUSH alone while FULL SHALL cause no write and no SP change, and SHALL set ERR.
REQ-014 POP alone while EMPTY SHALL cause no RAM access and no POP_VALID, and SHALL set ERR.
REQ-015 POP_VALID SHALL be high for exactly one cycle per accepted pop; POP_DATA SHALL hold its value otherwise.
REQ-016 SP SHALL wrap naturally: a push from SP=0 SHALL give SP=255, and a pop from SP=255 SHALL give SP=0.
REQ-017 CLEAR in IDLE SHALL move the FSM to CLR with a clear address of 0; BUSY SHALL be high while in CLR.
REQ-018 In CLR, each cycle SHALL drive SCR_ADDR = clear address, SCR_DATA_OUT = 0 and SCR_WE = 1, then increment the clear address.
REQ-019 After writing address 255 (256 cycles), the FSM SHALL return to IDLE with SP = 0, COUNT = 0 and ERR = 0.
REQ-020 PUSH, POP and CLEAR SHALL be ignored while BUSY, with no ERR and no POP_VALID.
REQ-021 In IDLE with no accepted request, SCR_WE SHALL be 0 and SCR_ADDR = SP.

Reset
REQ-022 On RST assertion, immediately and without a clock edge: state = IDLE, SP = 0, COUNT = 0, POP_DATA = 0, POP_VALID = 0, ERR = 0, BUSY = 0, and SCR_WE SHALL be forced to 0.
REQ-023 RST during CLR SHALL abort the sequence; RAM contents are left partially cleared.
REQ-024 RST SHALL NOT clear RAM contents.

Verification
REQ-025 The bench SHALL cover these directed scenarios against a scratch RAM model:
- After reset, push 0x155 then 0x2AA -> writes at address 255 then 254; SP = 254; EMPTY = 0.
- Then pop twice -> POP_DATA = 0x2AA then 0x155, each with a 1-cycle POP_VALID; SP = 0; EMPTY = 1.
- Pop while EMPTY -> ERR = 1, POP_VALID = 0, SP = 0; ERR stays set until RST or CLEAR completes.
- Push 256 words -> FULL = 1, SP = 0; a 257th push -> no SCR_WE, ERR = 1.
- Push 0x001, then PUSH and POP together with 0x3FF -> POP_DATA = 0x001; RAM[255] = 0x3FF; SP = 255.
- CLEAR -> BUSY high for 256 cycles, all RAM words 0, SP = 0; PUSH during BUSY is ignored; RST at cycle 100 -> IDLE, BUSY = 0.
